// File: rtl/lod_pkg.sv
// Shared widths, the "no bit set" code and the sequencer state encoding
// for the leading-one bit-scan sequencer.
package lod_pkg;

  localparam int DATA_W = 32;
  localparam int POS_W  = 6;
  localparam logic [POS_W-1:0] POS_NONE = 6'd32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    EMPTY = 2'd2
  } state_t;

endpackage

// File: rtl/leading_one_pos.sv
// Combinational 32-bit leading-one detector: bit 31 is position 0, bit 0 is
// position 31, and an all-zero input yields POS_NONE.
module leading_one_pos
  import lod_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [POS_W-1:0]  pos
);

  // Scanning upward lets the most significant set bit overwrite lower ones.
  always_comb begin
    pos = POS_NONE;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) begin
        pos = POS_W'(DATA_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/lod_bitscan_sequencer.sv
// Accepts a mask, then reports every set bit MSB first (one per output beat),
// clearing each reported bit until the mask is empty.
module lod_bitscan_sequencer
  import lod_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [POS_W-1:0]  out_pos,
  output logic              out_last,
  output logic              busy,
  output logic [POS_W-1:0]  beat_cnt
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [POS_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [POS_W-1:0]  lod_pos;
  logic [4:0]        clr_idx;
  logic              single_bit;

  leading_one_pos u_lod (
    .data (work_q),
    .pos  (lod_pos)
  );

  // In SCAN the position is below 32, so 31-pos is just the low five bits inverted.
  assign clr_idx    = ~lod_pos[4:0];
  assign single_bit = (work_q != '0) && ((work_q & (work_q - 32'd1)) == '0);

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    beat_cnt_d = beat_cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_pos    = '0;
    out_last   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d     = in_data;
          beat_cnt_d = '0;
          state_d    = (in_data != '0) ? SCAN : EMPTY;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_pos   = lod_pos;
        out_last  = single_bit;
        if (out_ready) begin
          work_d     = work_q & ~(32'd1 << clr_idx);
          beat_cnt_d = beat_cnt_q + 6'd1;
          if (single_bit) begin
            state_d = IDLE;
          end
        end
      end
      EMPTY: begin
        out_valid = 1'b1;
        out_pos   = POS_NONE;
        out_last  = 1'b1;
        if (out_ready) begin
          beat_cnt_d = 6'd1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides both handshakes: a load in the same cycle is dropped.
    if (abort) begin
      state_d    = IDLE;
      work_d     = '0;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign beat_cnt = beat_cnt_q;

endmodule
